// File: rtl/udp_decoder.sv
// UDP stage behind the IPv4 decoder: parses the 8-byte UDP header, forwards the
// payload with tail bytes masked, and checks the UDP checksum over the pseudo-header.
module udp_decoder #(
    parameter logic [7:0] UDP_PROTO = 8'd17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic        in_wr_en,
    input  logic        in_fin,
    input  logic        in_ok,
    input  logic [31:0] src_ip,
    input  logic [31:0] dest_ip,
    input  logic [7:0]  protocol,
    output logic [15:0] src_port,
    output logic [15:0] dest_port,
    output logic [15:0] udp_length,
    output logic [15:0] udp_chks,
    output logic [31:0] data_out,
    output logic        wr_en,
    output logic        fin,
    output logic        ok
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR2    = 3'd1,
        DATA    = 3'd2,
        WAIT_IP = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] bytes_left;
    logic [31:0] acc;
    logic        trunc;
    logic        len_err;

    logic [15:0] len_in;
    logic [31:0] mask;
    logic [31:0] word_m;
    logic [16:0] word_sum;
    logic [31:0] preload;
    logic [16:0] fold1;
    logic [15:0] sum16;

    assign len_in = in_data[31:16];

    // Only the final payload word of a non-multiple-of-4 length is trimmed.
    always_comb begin
        mask = 32'hFFFF_FFFF;
        if (state == DATA) begin
            case (bytes_left)
                16'd1:   mask = 32'hFF00_0000;
                16'd2:   mask = 32'hFFFF_0000;
                16'd3:   mask = 32'hFFFF_FF00;
                default: mask = 32'hFFFF_FFFF;
            endcase
        end
        word_m = in_data & mask;
    end

    assign word_sum = {1'b0, word_m[31:16]} + {1'b0, word_m[15:0]};
    assign preload  = {16'h0, src_ip[31:16]}  + {16'h0, src_ip[15:0]}
                    + {16'h0, dest_ip[31:16]} + {16'h0, dest_ip[15:0]}
                    + 32'h0000_0011;

    // Second fold cannot carry again: the first fold is at most 0x1FFFE.
    assign fold1 = {1'b0, acc[31:16]} + {1'b0, acc[15:0]};
    assign sum16 = fold1[15:0] + {15'h0, fold1[16]};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_fin)        state_nxt = DONE;
                else if (in_wr_en) state_nxt = HDR2;
            end
            HDR2: begin
                if (in_fin)        state_nxt = DONE;
                else if (in_wr_en) state_nxt = (len_in <= 16'd8) ? WAIT_IP : DATA;
            end
            DATA: begin
                if (in_fin)                                 state_nxt = DONE;
                else if (in_wr_en && bytes_left <= 16'd4)   state_nxt = WAIT_IP;
            end
            WAIT_IP: begin
                if (in_fin) state_nxt = DONE;
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_port   <= '0;
            dest_port  <= '0;
            udp_length <= '0;
            udp_chks   <= '0;
            data_out   <= '0;
            wr_en      <= 1'b0;
            fin        <= 1'b0;
            ok         <= 1'b0;
            bytes_left <= '0;
            acc        <= '0;
            trunc      <= 1'b0;
            len_err    <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_fin) begin
                        fin   <= 1'b1;
                        trunc <= 1'b1;
                    end else if (in_wr_en) begin
                        src_port  <= in_data[31:16];
                        dest_port <= in_data[15:0];
                        acc       <= preload + {15'h0, word_sum};
                    end
                end
                HDR2: begin
                    if (in_fin) begin
                        fin   <= 1'b1;
                        trunc <= 1'b1;
                    end else if (in_wr_en) begin
                        udp_length <= len_in;
                        udp_chks   <= in_data[15:0];
                        acc        <= acc + {16'h0, len_in} + {15'h0, word_sum};
                        bytes_left <= (len_in > 16'd8) ? len_in - 16'd8 : 16'd0;
                        len_err    <= (len_in < 16'd8);
                    end
                end
                DATA: begin
                    if (in_fin) begin
                        fin   <= 1'b1;
                        trunc <= 1'b1;
                    end else if (in_wr_en) begin
                        data_out   <= word_m;
                        wr_en      <= 1'b1;
                        acc        <= acc + {15'h0, word_sum};
                        bytes_left <= (bytes_left > 16'd4) ? bytes_left - 16'd4 : 16'd0;
                    end
                end
                WAIT_IP: begin
                    if (in_fin) fin <= 1'b1;
                end
                DONE: begin
                    ok <= in_ok & (protocol == UDP_PROTO) & ~trunc & ~len_err
                        & ((udp_chks == 16'h0) | (sum16 == 16'hFFFF));
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_decoder.sv
// Directed bench for udp_decoder: payload words scoreboarded through a queue,
// header fields and fin/ok checked against hand-derived values per packet.
module tb_udp_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic        in_wr_en;
    logic        in_fin;
    logic        in_ok;
    logic [31:0] src_ip;
    logic [31:0] dest_ip;
    logic [7:0]  protocol;
    logic [15:0] src_port, dest_port, udp_length, udp_chks;
    logic [31:0] data_out;
    logic        wr_en, fin, ok;

    int tests_run = 0;
    int tests_failed = 0;
    int wr_count = 0;
    logic [31:0] exp_q[$];

    udp_decoder dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_wr_en(in_wr_en), .in_fin(in_fin), .in_ok(in_ok),
        .src_ip(src_ip), .dest_ip(dest_ip), .protocol(protocol),
        .src_port(src_port), .dest_port(dest_port),
        .udp_length(udp_length), .udp_chks(udp_chks),
        .data_out(data_out), .wr_en(wr_en), .fin(fin), .ok(ok)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Payload scoreboard: every wr_en pops one expected word.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_wr_en", data_out, 32'hXXXX_XXXX);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("data_out", data_out, e);
            end
        end
    end

    task automatic drive(input logic [31:0] w);
        in_data  = w;
        in_wr_en = 1'b1;
        @(posedge clk); #1;
        in_wr_en = 1'b0;
    endtask

    task automatic drive_data(input logic [31:0] w, input logic [31:0] exp);
        exp_q.push_back(exp);
        drive(w);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        in_wr_en = 1'b0;
        reset = 1'b1;
        idle(2);
        in_fin = 1'b0;
        in_ok  = 1'b0;
        idle(1);
        check("rst_outputs", {src_port, dest_port}, 32'h0);
        check("rst_hdr", {udp_length, udp_chks}, 32'h0);
        check("rst_flags", {31'h0, wr_en | fin | ok | (|data_out)}, 32'h0);
        reset = 1'b0;
        exp_q.delete();
        wr_count = 0;
        idle(1);
    endtask

    task automatic end_pkt(input logic ok_in);
        int n;
        in_fin = 1'b1;
        in_ok  = ok_in;
        n = 0;
        while (fin !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("fin_rise", {31'h0, fin}, 32'h1);
        idle(2);
    endtask

    task automatic check_pkt(input string tag, input logic [15:0] len, input logic [15:0] chk,
                             input logic exp_ok, input int nwr);
        check({tag, "_ports"}, {src_port, dest_port}, 32'h1234_0050);
        check({tag, "_len_chks"}, {udp_length, udp_chks}, {len, chk});
        check({tag, "_fin"}, {31'h0, fin}, 32'h1);
        check({tag, "_ok"}, {31'h0, ok}, {31'h0, exp_ok});
        check({tag, "_wr_count"}, wr_count, nwr);
        check({tag, "_q_empty"}, exp_q.size(), 0);
    endtask

    task automatic run_t1(input logic [31:0] hdr2, input logic [15:0] chk, input logic exp_ok,
                          input string tag);
        drive(32'h1234_0050);
        idle(1);
        drive(hdr2);
        idle(2);
        drive_data(32'hDEAD_BEEF, 32'hDEAD_BEEF);
        end_pkt(1'b1);
        check_pkt(tag, 16'h000C, chk, exp_ok, 1);
    endtask

    initial begin
        reset = 1'b1; in_data = '0; in_wr_en = 1'b0; in_fin = 1'b0; in_ok = 1'b0;
        src_ip = 32'hC0A8_0001; dest_ip = 32'hC0A8_00C7; protocol = 8'd17;
        idle(1);
        do_reset();

        // T1 basic, with idle gaps between words
        run_t1(32'h000C_CD9B, 16'hCD9B, 1'b1, "t1");
        do_reset();

        // T2 bad checksum
        run_t1(32'h000C_CD9A, 16'hCD9A, 1'b0, "t2");
        do_reset();

        // T3 tail mask with IP padding; CE8C is the checksum of the masked payload
        drive(32'h1234_0050);
        drive(32'h000B_CE8C);
        drive_data(32'hDEAD_BEEF, 32'hDEAD_BE00);
        drive(32'h1122_3344);
        end_pkt(1'b1);
        check_pkt("t3", 16'h000B, 16'hCE8C, 1'b1, 1);
        do_reset();

        // T4 zero checksum accepted; wrong protocol rejected
        run_t1(32'h000C_0000, 16'h0000, 1'b1, "t4a");
        do_reset();
        protocol = 8'h06;
        run_t1(32'h000C_0000, 16'h0000, 1'b0, "t4b");
        protocol = 8'd17;
        do_reset();

        // T5 truncation in DATA
        drive(32'h1234_0050);
        drive(32'h0014_0000);
        drive_data(32'hDEAD_BEEF, 32'hDEAD_BEEF);
        end_pkt(1'b1);
        check_pkt("t5", 16'h0014, 16'h0000, 1'b0, 1);
        do_reset();

        // T6 reset while in DATA, then a clean packet
        drive(32'h1234_0050);
        drive(32'h0014_0000);
        idle(1);
        do_reset();
        run_t1(32'h000C_CD9B, 16'hCD9B, 1'b1, "t6");
        do_reset();

        // Length below header size is an error even with zero checksum
        drive(32'h1234_0050);
        drive(32'h0004_0000);
        end_pkt(1'b1);
        check_pkt("lenerr", 16'h0004, 16'h0000, 1'b0, 0);
        do_reset();

        // fin with no words at all
        end_pkt(1'b1);
        check("nowords_ok", {31'h0, ok}, 32'h0);
        check("nowords_wr", wr_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
